// File: rtl/dds_multich.sv
// N_CH-channel DDS (sine/square/triangle/sawtooth) with phase offset, amplitude scaling and
// double-buffered configuration. Define DDS_SWEEP_EN to add the per-channel linear frequency sweep.
module dds_multich #(
  parameter int N_CH      = 2,
  parameter int ACC_W     = 30,
  parameter int LUT_AW    = 8,
  parameter int OUT_W     = 8,
  parameter int SWEEP_DIV = 1024,
  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  sclk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [2:0]            cfg_addr,
  input  logic [ACC_W-1:0]      cfg_data,
  input  logic                  cfg_load,
  input  logic                  sync_clr,
  output logic [N_CH*OUT_W-1:0] o_wave,
  output logic                  o_valid,
  output logic                  clk_DA
);
  localparam int  LUT_N = 2 ** LUT_AW;
  localparam int  MID_I = 2 ** (OUT_W - 1);
  localparam real PI    = 3.14159265358979;
  localparam logic [OUT_W-1:0] MID = {1'b1, {(OUT_W-1){1'b0}}};

  // Sine table, filled at elaboration
  logic [OUT_W-1:0] lut [LUT_N];
  for (genvar k = 0; k < LUT_N; k++) begin : g_lut
    localparam real ANG = 2.0 * PI * k / LUT_N;
    localparam int  VAL = $rtoi(MID_I + (MID_I - 1) * $sin(ANG) + 0.5);
    assign lut[k] = OUT_W'(VAL);
  end

  logic [ACC_W-1:0] sh_fc_q [N_CH], sh_fc_d [N_CH], act_fc_q [N_CH], act_fc_d [N_CH];
  logic [ACC_W-1:0] sh_pc_q [N_CH], sh_pc_d [N_CH], act_pc_q [N_CH], act_pc_d [N_CH];
  logic [1:0]       sh_mode_q [N_CH], sh_mode_d [N_CH], act_mode_q [N_CH], act_mode_d [N_CH];
  logic [8:0]       sh_amp_q [N_CH], sh_amp_d [N_CH], act_amp_q [N_CH], act_amp_d [N_CH];
  logic [ACC_W-1:0] acc_q [N_CH], acc_d [N_CH], p1_pc_q [N_CH], p1_pc_d [N_CH];
  logic [1:0]       p1_mode_q [N_CH], p1_mode_d [N_CH];
  logic [8:0]       p1_amp_q [N_CH], p1_amp_d [N_CH], p2_amp_q [N_CH], p2_amp_d [N_CH];
  logic [OUT_W-1:0] smp_q [N_CH], smp_d [N_CH], wave_q [N_CH], wave_d [N_CH];
  logic [2:0]       valid_q, valid_d;
  logic [N_CH-1:0]  unused_bits;
`ifdef DDS_SWEEP_EN
  localparam int DIV_W = (SWEEP_DIV > 1) ? $clog2(SWEEP_DIV) : 1;
  logic [ACC_W-1:0] sh_step_q [N_CH], sh_step_d [N_CH], act_step_q [N_CH], act_step_d [N_CH];
  logic [ACC_W-1:0] sh_end_q [N_CH], sh_end_d [N_CH], act_end_q [N_CH], act_end_d [N_CH];
  logic [ACC_W-1:0] fc_run_q [N_CH], fc_run_d [N_CH];
  logic [DIV_W-1:0] div_q, div_d;
`endif

  // Next-state logic: config write/load, accumulators, waveform shaping and amplitude scaling
  always_comb begin
    logic                     wr;
    logic [ACC_W-1:0]         fc_use, ph;
    logic [OUT_W-1:0]         tri_s, raw;
    logic [8:0]               amp_s;
    logic signed [OUT_W:0]    diff;
    logic signed [OUT_W+10:0] prod, res;
`ifdef DDS_SWEEP_EN
    logic                     tick;
    logic signed [ACC_W+1:0]  nxt, end_s;
    tick  = !cfg_load && (div_q == DIV_W'(SWEEP_DIV - 1));
    div_d = (cfg_load || tick) ? {DIV_W{1'b0}} : div_q + {{(DIV_W-1){1'b0}}, 1'b1};
    nxt   = {(ACC_W+2){1'b0}};
    end_s = {(ACC_W+2){1'b0}};
`endif
    wr = 1'b0; fc_use = {ACC_W{1'b0}}; ph = {ACC_W{1'b0}};
    tri_s = {OUT_W{1'b0}}; raw = {OUT_W{1'b0}}; amp_s = 9'd0;
    diff = {(OUT_W+1){1'b0}}; prod = {(OUT_W+11){1'b0}}; res = {(OUT_W+11){1'b0}};
    unused_bits = {N_CH{1'b0}};
    valid_d = {valid_q[1:0], 1'b1};
    for (int c = 0; c < N_CH; c++) begin
      wr = cfg_we && (cfg_ch == CH_W'(c));
      sh_fc_d[c] = sh_fc_q[c]; sh_pc_d[c] = sh_pc_q[c];
      sh_mode_d[c] = sh_mode_q[c]; sh_amp_d[c] = sh_amp_q[c];
`ifdef DDS_SWEEP_EN
      sh_step_d[c] = sh_step_q[c]; sh_end_d[c] = sh_end_q[c];
`endif
      case ({wr, cfg_addr})
        4'b1000: sh_fc_d[c]   = cfg_data;
        4'b1001: sh_pc_d[c]   = cfg_data;
        4'b1010: sh_mode_d[c] = cfg_data[1:0];
        4'b1011: sh_amp_d[c]  = cfg_data[8:0];
`ifdef DDS_SWEEP_EN
        4'b1100: sh_step_d[c] = cfg_data;
        4'b1101: sh_end_d[c]  = cfg_data;
`endif
        default: ;
      endcase
      act_fc_d[c]   = cfg_load ? sh_fc_q[c]   : act_fc_q[c];
      act_pc_d[c]   = cfg_load ? sh_pc_q[c]   : act_pc_q[c];
      act_mode_d[c] = cfg_load ? sh_mode_q[c] : act_mode_q[c];
      act_amp_d[c]  = cfg_load ? sh_amp_q[c]  : act_amp_q[c];
`ifdef DDS_SWEEP_EN
      act_step_d[c] = cfg_load ? sh_step_q[c] : act_step_q[c];
      act_end_d[c]  = cfg_load ? sh_end_q[c]  : act_end_q[c];
      nxt   = $signed({2'b00, fc_run_q[c]}) + $signed({{2{act_step_q[c][ACC_W-1]}}, act_step_q[c]});
      end_s = $signed({2'b00, act_end_q[c]});
      if (cfg_load) begin
        fc_run_d[c] = sh_fc_q[c];
      end else if (tick && (act_step_q[c] != {ACC_W{1'b0}}) && (fc_run_q[c] != act_end_q[c])) begin
        // Reaching or crossing the end point in the step's direction clamps and holds
        if (act_step_q[c][ACC_W-1] ? (nxt <= end_s) : (nxt >= end_s)) begin
          fc_run_d[c] = act_end_q[c];
        end else begin
          fc_run_d[c] = nxt[ACC_W-1:0];
        end
      end else begin
        fc_run_d[c] = fc_run_q[c];
      end
      fc_use = fc_run_q[c];
`else
      fc_use = act_fc_q[c];
`endif
      acc_d[c] = sync_clr ? {ACC_W{1'b0}} : acc_q[c] + fc_use;
      // Offset/mode/amp travel with the sample so a load never mixes old and new settings
      p1_pc_d[c] = act_pc_q[c]; p1_mode_d[c] = act_mode_q[c];
      p1_amp_d[c] = act_amp_q[c]; p2_amp_d[c] = p1_amp_q[c];
      ph    = acc_q[c] + p1_pc_q[c];
      tri_s = ph[ACC_W-2 -: OUT_W];
      case (p1_mode_q[c])
        2'd0:    raw = lut[ph[ACC_W-1 -: LUT_AW]];
        2'd1:    raw = ph[ACC_W-1] ? {OUT_W{1'b0}} : {OUT_W{1'b1}};
        2'd2:    raw = ph[ACC_W-1] ? ~tri_s : tri_s;
        default: raw = ph[ACC_W-1 -: OUT_W];
      endcase
      smp_d[c] = raw;
      amp_s = (p2_amp_q[c] > 9'd256) ? 9'd256 : p2_amp_q[c];
      diff  = $signed({1'b0, smp_q[c]}) - $signed({1'b0, MID});
      prod  = (OUT_W+11)'(diff) * (OUT_W+11)'($signed({1'b0, amp_s}));
      res   = (prod >>> 8) + (OUT_W+11)'($signed({1'b0, MID}));
      wave_d[c] = res[OUT_W-1:0];
      unused_bits[c] = ^{ph, res};
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        sh_fc_q[c] <= {ACC_W{1'b0}}; act_fc_q[c] <= {ACC_W{1'b0}};
        sh_pc_q[c] <= {ACC_W{1'b0}}; act_pc_q[c] <= {ACC_W{1'b0}};
        sh_mode_q[c] <= 2'd0; act_mode_q[c] <= 2'd0; p1_mode_q[c] <= 2'd0;
        sh_amp_q[c] <= 9'd256; act_amp_q[c] <= 9'd256;
        p1_amp_q[c] <= 9'd256; p2_amp_q[c] <= 9'd256;
        acc_q[c] <= {ACC_W{1'b0}}; p1_pc_q[c] <= {ACC_W{1'b0}};
        smp_q[c] <= MID; wave_q[c] <= MID;
`ifdef DDS_SWEEP_EN
        sh_step_q[c] <= {ACC_W{1'b0}}; act_step_q[c] <= {ACC_W{1'b0}};
        sh_end_q[c] <= {ACC_W{1'b0}}; act_end_q[c] <= {ACC_W{1'b0}};
        fc_run_q[c] <= {ACC_W{1'b0}};
`endif
      end
      valid_q <= 3'b000;
`ifdef DDS_SWEEP_EN
      div_q <= {DIV_W{1'b0}};
`endif
    end else begin
      sh_fc_q <= sh_fc_d; act_fc_q <= act_fc_d; sh_pc_q <= sh_pc_d; act_pc_q <= act_pc_d;
      sh_mode_q <= sh_mode_d; act_mode_q <= act_mode_d; p1_mode_q <= p1_mode_d;
      sh_amp_q <= sh_amp_d; act_amp_q <= act_amp_d; p1_amp_q <= p1_amp_d; p2_amp_q <= p2_amp_d;
      acc_q <= acc_d; p1_pc_q <= p1_pc_d; smp_q <= smp_d; wave_q <= wave_d;
      valid_q <= valid_d;
`ifdef DDS_SWEEP_EN
      sh_step_q <= sh_step_d; act_step_q <= act_step_d;
      sh_end_q <= sh_end_d; act_end_q <= act_end_d;
      fc_run_q <= fc_run_d; div_q <= div_d;
`endif
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_out
    assign o_wave[c*OUT_W +: OUT_W] = wave_q[c];
  end
  assign o_valid = valid_q[2];
  assign clk_DA  = ~sclk;
endmodule

// File: tb/tb_dds_multich.sv
// Directed self-checking bench for dds_multich (N_CH=2, ACC_W=30, LUT_AW=8, OUT_W=8, SWEEP_DIV=4).
module tb_dds_multich;
  logic        sclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [0:0]  cfg_ch = 1'b0;
  logic [2:0]  cfg_addr = 3'd0;
  logic [29:0] cfg_data = 30'd0;
  logic        cfg_load = 1'b0;
  logic        sync_clr = 1'b0;
  logic [15:0] o_wave;
  logic        o_valid;
  logic        clk_DA;
  int checks = 0;
  int errors = 0;

  dds_multich #(.SWEEP_DIV(4)) dut (
    .sclk(sclk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_load(cfg_load), .sync_clr(sync_clr),
    .o_wave(o_wave), .o_valid(o_valid), .clk_DA(clk_DA)
  );

  always #5 sclk = ~sclk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge sclk);
      #1;
    end
  endtask

  task automatic cfg_write(input logic ch, input logic [2:0] addr, input logic [29:0] data);
    cfg_we = 1'b1; cfg_ch = ch; cfg_addr = addr; cfg_data = data;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic load();
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(3);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (o_valid !== 1'b0 || o_wave !== 16'h8080) begin
        errors++;
        $display("FAIL reset_hold: valid=%b wave=%h, expected 0/8080", o_valid, o_wave);
      end
    end
    checks++;
    if (clk_DA !== 1'b0) begin
      errors++;
      $display("FAIL clk_da: got %b expected 0 after rising sclk", clk_DA);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (o_valid !== 1'b0 || o_wave !== 16'h8080) begin
        errors++;
        $display("FAIL reset_release_%0d: valid=%b wave=%h, expected 0/8080", i, o_valid, o_wave);
      end
    end
    step();
    checks++;
    if (o_valid !== 1'b1 || o_wave !== 16'h8080) begin
      errors++;
      $display("FAIL valid_rise: valid=%b wave=%h, expected 1/8080", o_valid, o_wave);
    end
    #5;
    checks++;
    if (clk_DA !== 1'b1) begin
      errors++;
      $display("FAIL clk_da_low: got %b expected 1 while sclk low", clk_DA);
    end
  endtask

  task automatic test_sawtooth();
    logic [7:0] exp_b;
    do_reset();
    cfg_write(1'b0, 3'd2, 30'd3);
    cfg_write(1'b0, 3'd0, 30'h0040_0000);
    load();
    step(2);
    for (int n = 0; n < 260; n++) begin
      step();
      exp_b = 8'(n + 1);
      checks++;
      if (o_wave !== {8'h80, exp_b}) begin
        errors++;
        $display("FAIL sawtooth_%0d: wave=%h expected %h", n, o_wave, {8'h80, exp_b});
      end
    end
  endtask

  task automatic test_square();
    logic [7:0]  k8;
    logic [15:0] exp_w;
    do_reset();
    cfg_write(1'b0, 3'd2, 30'd1);
    cfg_write(1'b0, 3'd0, 30'h0040_0000);
    cfg_write(1'b1, 3'd2, 30'd1);
    cfg_write(1'b1, 3'd0, 30'h0040_0000);
    cfg_write(1'b1, 3'd1, 30'h2000_0000);
    load();
    step(2);
    for (int n = 0; n < 300; n++) begin
      step();
      k8 = 8'(n + 1);
      exp_w = k8[7] ? 16'hFF00 : 16'h00FF;
      checks++;
      if (o_wave !== exp_w) begin
        errors++;
        $display("FAIL square_%0d: wave=%h expected %h", n, o_wave, exp_w);
      end
    end
    rst_n = 1'b0;
    step();
    checks++;
    if (o_wave !== 16'h8080 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_midrun: valid=%b wave=%h, expected 0/8080", o_valid, o_wave);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_amplitude();
    logic [29:0] pcs  [4] = '{30'h1000_0000, 30'h1000_0000, 30'h1000_0000, 30'h3000_0000};
    logic [29:0] amps [4] = '{30'd128, 30'd0, 30'd300, 30'd128};
    logic [15:0] exps [4] = '{16'h80BF, 16'h8080, 16'h80FF, 16'h8040};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cfg_write(1'b0, 3'd1, pcs[i]);
      cfg_write(1'b0, 3'd3, amps[i]);
      load();
      step(3);
      checks++;
      if (o_wave !== exps[i]) begin
        errors++;
        $display("FAIL amplitude_%0d: wave=%h expected %h", i, o_wave, exps[i]);
      end
    end
  endtask

  task automatic test_triangle();
    do_reset();
    cfg_write(1'b0, 3'd2, 30'd2);
    cfg_write(1'b0, 3'd1, 30'h0800_0000);
    cfg_write(1'b1, 3'd2, 30'd2);
    cfg_write(1'b1, 3'd1, 30'h2800_0000);
    load();
    step(3);
    checks++;
    if (o_wave !== 16'hBF40) begin
      errors++;
      $display("FAIL triangle: wave=%h expected bf40", o_wave);
    end
  endtask

  task automatic test_config_buffer();
    do_reset();
    cfg_write(1'b0, 3'd0, 30'h0040_0000);
    cfg_write(1'b1, 3'd0, 30'h0040_0000);
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (o_wave !== 16'h8080) begin
        errors++;
        $display("FAIL shadow_hold_%0d: wave=%h expected 8080", i, o_wave);
      end
    end
    // Write to ch0 in the same cycle as the load: load must take the old shadow value
    cfg_we = 1'b1; cfg_ch = 1'b0; cfg_addr = 3'd0; cfg_data = 30'h0080_0000;
    load();
    cfg_we = 1'b0;
    step(2);
    checks++;
    if (o_wave !== 16'h8080) begin
      errors++;
      $display("FAIL load_l2: wave=%h expected 8080", o_wave);
    end
    step();
    checks++;
    if (o_wave !== 16'h8383) begin
      errors++;
      $display("FAIL load_l3: wave=%h expected 8383", o_wave);
    end
    step();
    checks++;
    if (o_wave !== 16'h8686) begin
      errors++;
      $display("FAIL load_l4: wave=%h expected 8686", o_wave);
    end
    step(6);
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    step(2);
    checks++;
    if (o_wave !== 16'h8080) begin
      errors++;
      $display("FAIL sync_clr_c2: wave=%h expected 8080", o_wave);
    end
    step();
    checks++;
    if (o_wave !== 16'h8383) begin
      errors++;
      $display("FAIL sync_clr_c3: wave=%h expected 8383", o_wave);
    end
    cfg_load = 1'b1; sync_clr = 1'b1;
    step();
    cfg_load = 1'b0; sync_clr = 1'b0;
    step(2);
    checks++;
    if (o_wave !== 16'h8080) begin
      errors++;
      $display("FAIL load_clr_2: wave=%h expected 8080", o_wave);
    end
    step();
    checks++;
    if (o_wave !== 16'h8386) begin
      errors++;
      $display("FAIL load_clr_3: wave=%h expected 8386", o_wave);
    end
  endtask

  task automatic test_sweep();
    do_reset();
    cfg_write(1'b0, 3'd0, 30'd0);
    cfg_write(1'b0, 3'd4, 30'h0010_0000);
    cfg_write(1'b0, 3'd5, 30'h0040_0000);
`ifdef DDS_SWEEP_EN
    cfg_write(1'b0, 3'd2, 30'd3);
    load();
    step(19);
    for (int t = 20; t < 30; t++) begin
      step();
      checks++;
      if (o_wave !== {8'h80, 8'(t - 12)}) begin
        errors++;
        $display("FAIL sweep_%0d: wave=%h expected %h", t, o_wave, {8'h80, 8'(t - 12)});
      end
    end
`else
    load();
    for (int i = 0; i < 40; i++) begin
      step();
      checks++;
      if (o_wave !== 16'h8080) begin
        errors++;
        $display("FAIL sweep_off_%0d: wave=%h expected 8080", i, o_wave);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_sawtooth();
    test_square();
    test_amplitude();
    test_triangle();
    test_config_buffer();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dds_multich.md
# dds_multich

- Parametrised multi-channel DDS waveform generator, the next generation of the single-channel 8-bit sine DDS.
- Provides N_CH independent phase-accumulator channels.
- Each channel has run-time selectable sine, square, triangle or sawtooth waveform, a phase offset and amplitude scaling.
- Configuration is double-buffered and applied to all channels atomically.
- Sits between the key/host control logic and the parallel DAC pins.

## Interface
- N_CH, 2, number of channels (1..8)
- ACC_W, 30, phase accumulator / frequency / phase word width
- LUT_AW, 8, sine LUT address width (2^LUT_AW entries)
- OUT_W, 8, sample width per channel, offset-binary
- SWEEP_DIV, 1024, sweep update period in sclk cycles (used only with DDS_SWEEP_EN)

Ports:
- sclk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- cfg_we  in  1  write cfg_data into the shadow register selected by cfg_ch/cfg_addr
- cfg_ch  in  max(1,$clog2(N_CH))  target channel; values >= N_CH are ignored
- cfg_addr  in  3  0=fc, 1=pc, 2=mode[1:0], 3=amp[8:0], 4=sweep step (signed), 5=sweep end fc
- cfg_data  in  ACC_W  write data, LSB-aligned
- cfg_load  in  1  copy all shadow registers to active registers, all channels, same edge
- sync_clr  in  1  zero every channel accumulator
- o_wave  out  N_CH*OUT_W  channel c at [c*OUT_W +: OUT_W]
- o_valid  out  1  pipeline holds valid samples
- clk_DA  out  1  DAC latch clock, equal to ~sclk

## Operation
- Reset (rst_n=0 at edge) sets the following for every channel:
  - acc = 0 and shadow/active fc = 0, pc = 0
  - mode = 0 (sine), amp = 256, sweep step = 0, sweep end = 0
  - pipeline sample registers = midscale 2^(OUT_W-1)
  - o_valid = 0
- Accumulator, per channel per cycle: acc <= acc + fc_active, modulo 2^ACC_W.
  - sync_clr has priority and forces acc <= 0.
- Phase: ph = acc + pc_active, modulo 2^ACC_W.
- Waveform from ph, with mode:
  - 0 sine: LUT[ph[ACC_W-1 -: LUT_AW]]. LUT[k] = round(2^(OUT_W-1) + (2^(OUT_W-1)-1)*sin(2πk/2^LUT_AW)), filled at elaboration.
  - 1 square: ph MSB=0 gives all-ones, otherwise 0.
  - 2 triangle: s = ph[ACC_W-2 -: OUT_W]; output is s when MSB=0, ~s when MSB=1.
  - 3 sawtooth: ph[ACC_W-1 -: OUT_W].
- Amplitude:
  - out = mid + ((sample - mid) * amp) >>> 8, using signed arithmetic, with arithmetic shift (floor).
  - amp > 256 is saturated to 256, so the result never exceeds OUT_W.
- Shadow/active configuration:
  - cfg_we writes the shadow register only; active registers change only on cfg_load.
  - cfg_we and cfg_load in the same cycle: the load copies the pre-write shadow, and the write lands in shadow for the next load.
  - cfg_load and sync_clr in the same cycle: acc = 0, and the new fc is used from the next cycle.
- clk_DA toggles during reset. o_wave changes on rising sclk edges, so the DAC samples mid-eye on the rising edge of clk_DA.

## Timing
- Pipeline: acc register (edge k), then sample register (edge k+1), then scaled o_wave register (edge k+2).
- Latency from acc update to o_wave is 2 cycles.
- cfg_load at edge L: the acc update at edge L+1 uses the new fc/pc/mode/amp. o_wave reflects it at edge L+3.
- sync_clr at edge C: o_wave shows the phase-0 sample of every channel at edge C+2.
- o_valid rises at the 3rd edge after rst_n is sampled high, then stays high until reset.
- Channels are phase-aligned cycle-exactly; no inter-channel skew.

## Configuration
- Macro: DDS_SWEEP_EN.
- Defined:
  - Each channel keeps fc_run, loaded from fc_active on cfg_load.
  - Every SWEEP_DIV cycles, fc_run += step.
  - On reaching or crossing the sweep end, fc_run clamps to the sweep end and holds.
  - step = 0 disables sweep.
  - The accumulator uses fc_run.
  - The sweep divider restarts on cfg_load and on reset.
- Undefined:
  - cfg_addr 4/5 writes are ignored.
  - The accumulator uses fc_active directly.
  - No sweep logic is synthesised.

## Test plan
Defaults for all scenarios: N_CH=2, ACC_W=30, LUT_AW=8, OUT_W=8.

- Reset: hold rst_n=0 for 4 cycles, then release.
  - o_wave=16'h8080 and o_valid=0 for 2 edges.
  - o_valid=1 from the 3rd edge onward.
- Sawtooth ch0: fc=2^22, mode=3, then cfg_load.
  - o_wave[7:0] steps 0,1,2… by 1 per cycle.
  - It wraps 255→0 every 256 cycles.
- Square phase offset: both channels mode=1, fc=2^22; ch1 pc=2^29; one cfg_load.
  - ch0 and ch1 are always complementary (8'hFF/8'h00).
  - Transitions occur on the same edge.
- Amplitude: sine, fc=0, pc=2^28 (k=64), amp=128.
  - o_wave=191.
  - With amp=0, o_wave=128.
  - With amp=300, o_wave=255.
- Config buffering: cfg_we fc=2^22 on ch0 and ch1 without cfg_load.
  - No output change for 20 cycles.
  - After cfg_load, both channels start ramping on the same edge (L+3).
  - sync_clr 10 cycles later: both channels equal the phase-0 sample 2 edges later.
- Sweep (DDS_SWEEP_EN, SWEEP_DIV=4): fc=0, step=2^20, end=2^22, then cfg_load.
  - fc_run = 2^20, 2^21, 3·2^20, then 2^22 at 4-cycle intervals, and holds at 2^22.
  - Without the macro, the output stays constant at mid.
